// File: rtl/mul_sched_pkg.sv
// Shared definitions for the sequential 8x8 multiply scheduler.
// Holds the FSM state encoding, the step index type, the per-step shift
// table and nibble-select codes, and two small mask helpers.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step 0..3 = LL, HL, LH, HH
  typedef logic [1:0] step_t;

  // Shift per step, 4 bits per entry, step 0 in the low nibble: {8,4,4,0}
  localparam logic [15:0] SHIFT_TBL = {4'd8, 4'd4, 4'd4, 4'd0};

  // Bit i set: step i takes the high nibble of that operand
  localparam logic [3:0] SEL_A_HI = 4'b1010;
  localparam logic [3:0] SEL_B_HI = 4'b1100;

  // Index of the lowest set bit; 0 when the mask is empty (caller checks)
  function automatic step_t lowest_set(input logic [3:0] m);
    step_t s;
    s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) s = step_t'(i);
    end
    return s;
  endfunction

  // Mask bits strictly above step s, i.e. the steps still to be issued
  function automatic logic [3:0] mask_above(input logic [3:0] m, input step_t s);
    logic [3:0] r;
    case (s)
      2'd0:    r = m & 4'b1110;
      2'd1:    r = m & 4'b1100;
      2'd2:    r = m & 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul8u_step_sel.sv
// Combinational step selector.
// Ports:
//   lat_a, lat_b : latched operands of the operation in flight
//   step         : current step index
//   new_a, new_b : operands being offered for acceptance
//   nib_a, nib_b : nibbles for the shared 4x4 multiplier
//   shift        : left shift applied to this step's partial product
//   mask         : steps to issue for new_a/new_b
module mul8u_step_sel
  import mul_sched_pkg::*;
#(
  parameter int SKIP_ZERO = 1
) (
  input  logic [7:0] lat_a,
  input  logic [7:0] lat_b,
  input  step_t      step,
  input  logic [7:0] new_a,
  input  logic [7:0] new_b,
  output logic [3:0] nib_a,
  output logic [3:0] nib_b,
  output logic [3:0] shift,
  output logic [3:0] mask
);

  assign nib_a = SEL_A_HI[step] ? lat_a[7:4] : lat_a[3:0];
  assign nib_b = SEL_B_HI[step] ? lat_b[7:4] : lat_b[3:0];
  assign shift = SHIFT_TBL[{step, 2'b00} +: 4];

  for (genvar i = 0; i < 4; i++) begin : g_mask
    logic [3:0] w_na;
    logic [3:0] w_nb;
    assign w_na = SEL_A_HI[i] ? new_a[7:4] : new_a[3:0];
    assign w_nb = SEL_B_HI[i] ? new_b[7:4] : new_b[3:0];
    assign mask[i] = (SKIP_ZERO == 0) || ((w_na != 4'd0) && (w_nb != 4'd0));
  end

endmodule

// File: rtl/mul8u_seq_sched.sv
// Sequential 8x8 unsigned multiplier built on one shared external 4x4
// multiplier. Partial products LL, HL, LH, HH are issued one per cycle
// (zero-nibble steps optionally skipped) and accumulated into 16 bits.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready, a, b     : operand stream
//   mul_a, mul_b, mul_en, mul_p : shared 4x4 multiplier interface
//   out_valid/out_ready,product : result stream
//   busy, op_count              : status, completed handoffs (wrapping)
module mul8u_seq_sched
  import mul_sched_pkg::*;
#(
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  output logic             mul_en,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      r_acc;
  logic [3:0]       r_mask;
  step_t            r_step;
  logic [CNT_W-1:0] r_op_count;

  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [3:0]  w_shift;
  logic [3:0]  w_new_mask;
  logic [3:0]  w_rem;
  logic [15:0] w_pp;
  logic        w_accept;
  logic        w_handoff;

  mul8u_step_sel #(.SKIP_ZERO(SKIP_ZERO)) u_step_sel (
    .lat_a (r_a),
    .lat_b (r_b),
    .step  (r_step),
    .new_a (a),
    .new_b (b),
    .nib_a (w_nib_a),
    .nib_b (w_nib_b),
    .shift (w_shift),
    .mask  (w_new_mask)
  );

  assign w_rem     = mask_above(r_mask, r_step);
  assign w_pp      = {8'd0, mul_p} << w_shift;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = (r_state == ST_DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    mul_en      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_new_mask == 4'd0) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        mul_en      = 1'b1;
        w_state_nxt = (w_rem == 4'd0) ? ST_DONE : ST_STEP;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Handoff and a new accept can share one edge
          in_ready = 1'b1;
          if (in_valid) w_state_nxt = (w_new_mask == 4'd0) ? ST_DONE : ST_STEP;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= 8'd0;
      r_b        <= 8'd0;
      r_acc      <= 16'd0;
      r_mask     <= 4'd0;
      r_step     <= 2'd0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_acc  <= 16'd0;
        r_mask <= w_new_mask;
        r_step <= lowest_set(w_new_mask);
      end else if (r_state == ST_STEP) begin
        // Truncating add: approximate multipliers may overflow 16 bits
        r_acc  <= r_acc + w_pp;
        r_step <= lowest_set(w_rem);
      end
      if (w_handoff) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign mul_a    = mul_en ? w_nib_a : 4'd0;
  assign mul_b    = mul_en ? w_nib_b : 4'd0;
  assign product  = r_acc;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_mul8u_seq_sched.sv
// Directed and random checks of mul8u_seq_sched. Index 0 of every signal
// array is the SKIP_ZERO=0 instance, index 1 the SKIP_ZERO=1 instance.
// Each instance has its own exact 4x4 multiplier model attached.
module tb_mul8u_seq_sched;

  logic        clk;
  logic        rst_n;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  a [2];
  logic [7:0]  b [2];
  logic [3:0]  mul_a [2];
  logic [3:0]  mul_b [2];
  logic        mul_en [2];
  logic [7:0]  mul_p [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] product [2];
  logic        busy [2];
  logic [15:0] op_count [2];

  int          ntests;
  int          nfail;
  logic [15:0] exp_cnt [2];

  mul8u_seq_sched #(.SKIP_ZERO(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]),
    .mul_p(mul_p[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(product[0]), .busy(busy[0]), .op_count(op_count[0])
  );

  mul8u_seq_sched #(.SKIP_ZERO(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]),
    .mul_p(mul_p[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(product[1]), .busy(busy[1]), .op_count(op_count[1])
  );

  assign mul_p[0] = {4'd0, mul_a[0]} * {4'd0, mul_b[0]};
  assign mul_p[1] = {4'd0, mul_a[1]} * {4'd0, mul_b[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand the pending result off and check the counter and that it is gone
  task automatic handoff(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    exp_cnt[d]++;
    ntests++;
    if (op_count[d] !== exp_cnt[d]) begin
      nfail++;
      $display("FAIL handoff_op_count[%0d]: got %0d expected %0d", d, op_count[d], exp_cnt[d]);
    end
    ntests++;
    if (out_valid[d] !== 1'b0) begin
      nfail++;
      $display("FAIL handoff_out_valid_drop[%0d]: got %b expected 0", d, out_valid[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      ntests++;
      if ({in_ready[d], out_valid[d], mul_en[d], busy[d]} !== 4'b1000) begin
        nfail++;
        $display("FAIL reset_flags[%0d]: got rdy/vld/en/busy %b%b%b%b expected 1000",
                 d, in_ready[d], out_valid[d], mul_en[d], busy[d]);
      end
      ntests++;
      if ({product[d], op_count[d], mul_a[d], mul_b[d]} !== 40'd0) begin
        nfail++;
        $display("FAIL reset_values[%0d]: got product %h op_count %0d mul_a %h mul_b %h expected all 0",
                 d, product[d], op_count[d], mul_a[d], mul_b[d]);
      end
    end
    rst_n = 1'b1;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
  endtask

  task automatic test_full_ff();
    a[1] = 8'hFF; b[1] = 8'hFF; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ntests++;
      if ({mul_en[1], mul_a[1], mul_b[1], out_valid[1]} !== 10'b1_1111_1111_0) begin
        nfail++;
        $display("FAIL ff_step%0d: got en %b a %h b %h vld %b expected 1 F F 0",
                 s, mul_en[1], mul_a[1], mul_b[1], out_valid[1]);
      end
      tick();
    end
    ntests++;
    if (out_valid[1] !== 1'b1 || product[1] !== 16'hFE01) begin
      nfail++;
      $display("FAIL ff_product: got vld %b product %h expected 1 FE01", out_valid[1], product[1]);
    end
    handoff(1);
  endtask

  task automatic test_single_hl();
    a[1] = 8'h10; b[1] = 8'h01; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    ntests++;
    if ({mul_en[1], mul_a[1], mul_b[1], out_valid[1]} !== 10'b1_0001_0001_0) begin
      nfail++;
      $display("FAIL hl_step: got en %b a %h b %h vld %b expected 1 1 1 0",
               mul_en[1], mul_a[1], mul_b[1], out_valid[1]);
    end
    tick();
    ntests++;
    if (out_valid[1] !== 1'b1 || product[1] !== 16'h0010) begin
      nfail++;
      $display("FAIL hl_product: got vld %b product %h expected 1 0010", out_valid[1], product[1]);
    end
    handoff(1);
  endtask

  task automatic test_zero_operand();
    a[1] = 8'h00; b[1] = 8'hA5; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    ntests++;
    if (out_valid[1] !== 1'b1 || product[1] !== 16'h0000 || mul_en[1] !== 1'b0) begin
      nfail++;
      $display("FAIL zero_skip: got vld %b product %h en %b expected 1 0000 0",
               out_valid[1], product[1], mul_en[1]);
    end
    handoff(1);
    a[0] = 8'h00; b[0] = 8'hA5; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ntests++;
      if (mul_en[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
        nfail++;
        $display("FAIL zero_noskip_step%0d: got en %b vld %b expected 1 0", s, mul_en[0], out_valid[0]);
      end
      tick();
    end
    ntests++;
    if (out_valid[0] !== 1'b1 || product[0] !== 16'h0000) begin
      nfail++;
      $display("FAIL zero_noskip_product: got vld %b product %h expected 1 0000", out_valid[0], product[0]);
    end
    handoff(0);
  endtask

  task automatic test_back_to_back();
    a[1] = 8'h12; b[1] = 8'h34; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    for (int c = 0; c < 5; c++) begin
      ntests++;
      if (out_valid[1] !== 1'b1 || product[1] !== 16'h03A8 || in_ready[1] !== 1'b0) begin
        nfail++;
        $display("FAIL bp_hold%0d: got vld %b product %h rdy %b expected 1 03A8 0",
                 c, out_valid[1], product[1], in_ready[1]);
      end
      tick();
    end
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; a[1] = 8'h03; b[1] = 8'h05;
    #1;
    ntests++;
    if (in_ready[1] !== 1'b1) begin
      nfail++;
      $display("FAIL bp_in_ready: got %b expected 1", in_ready[1]);
    end
    tick();
    out_ready[1] = 1'b0; in_valid[1] = 1'b0;
    exp_cnt[1]++;
    ntests++;
    if (op_count[1] !== exp_cnt[1] || out_valid[1] !== 1'b0 || mul_en[1] !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_accept: got cnt %0d vld %b en %b expected %0d 0 1",
               op_count[1], out_valid[1], mul_en[1], exp_cnt[1]);
    end
    tick();
    ntests++;
    if (out_valid[1] !== 1'b1 || product[1] !== 16'h000F) begin
      nfail++;
      $display("FAIL b2b_product: got vld %b product %h expected 1 000F", out_valid[1], product[1]);
    end
    handoff(1);
  endtask

  task automatic test_reset_mid_op();
    a[1] = 8'hAB; b[1] = 8'hCD; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    ntests++;
    if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || op_count[1] !== 16'd0 || mul_en[1] !== 1'b0) begin
      nfail++;
      $display("FAIL midrst: got busy %b vld %b cnt %0d en %b expected 0 0 0 0",
               busy[1], out_valid[1], op_count[1], mul_en[1]);
    end
    rst_n = 1'b1;
    a[1] = 8'h0F; b[1] = 8'h0F; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    tick();
    ntests++;
    if (out_valid[1] !== 1'b1 || product[1] !== 16'h00E1) begin
      nfail++;
      $display("FAIL midrst_next: got vld %b product %h expected 1 00E1", out_valid[1], product[1]);
    end
    handoff(1);
  endtask

  task automatic test_random(input int d);
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] got;
    bit          done;
    int          waited;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      a[d] = ra[7:0]; b[d] = rb[7:0]; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
      #1;
      waited = 0;
      while (!in_ready[d] && waited < 20) begin
        tick();
        waited++;
      end
      ntests++;
      if (in_ready[d] !== 1'b1) begin
        nfail++;
        $display("FAIL rnd_accept[%0d] #%0d: got in_ready %b expected 1", d, n, in_ready[d]);
      end
      tick();
      in_valid[d] = 1'b0;
      done = 1'b0;
      got = 16'd0;
      for (int c = 0; c < 20 && !done; c++) begin
        out_ready[d] = 1'($urandom_range(0, 1));
        #1;
        if (out_valid[d] && out_ready[d]) begin
          got = product[d];
          done = 1'b1;
        end
        tick();
      end
      out_ready[d] = 1'b0;
      if (done) exp_cnt[d]++;
      ntests++;
      if (!done || got !== ra * rb) begin
        nfail++;
        $display("FAIL rnd_product[%0d] %h*%h: got %h (done %b) expected %h", d, ra[7:0], rb[7:0], got, done, ra * rb);
      end
      ntests++;
      if (out_valid[d] !== 1'b0) begin
        nfail++;
        $display("FAIL rnd_dup[%0d] #%0d: got out_valid %b after handoff expected 0", d, n, out_valid[d]);
      end
    end
    ntests++;
    if (op_count[d] !== exp_cnt[d]) begin
      nfail++;
      $display("FAIL rnd_op_count[%0d]: got %0d expected %0d", d, op_count[d], exp_cnt[d]);
    end
  endtask

  initial begin
    ntests = 0;
    nfail = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; a[d] = 8'd0; b[d] = 8'd0;
      exp_cnt[d] = 16'd0;
    end
    test_reset();
    test_full_ff();
    test_single_hl();
    test_zero_operand();
    test_back_to_back();
    test_reset_mid_op();
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
